uart_rx_deser: RTL and testbench

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_rx_deser_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_deser.sv | 150 +++++++++++++++
 tb/tb_uart_rx_deser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_deser_pkg.sv
// Shared constants for the monitor's UART receive path.
// Holds the receiver state encodings, the default bit divider and the
// datapath widths used by uart_rx_deser and its testbench.
`timescale 1ns/1ps
package uart_rx_deser_pkg;

    // 50 MHz clock / 115200 baud
    localparam int unsigned CLK_DIV_DEFAULT = 434;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    // Receiver FSM encodings (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRKWT = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output
`timescale 1ns/1ps
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Metastability filter chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver / deserializer feeding the monitor character decoder.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   rxd     - serial line, asynchronous, idle high, LSB first
//   rout    - last correctly framed byte, held until the next good byte
//   rout_en - one-cycle pulse: rout newly valid
//   frm_err - one-cycle pulse: stop bit sampled low
`timescale 1ns/1ps
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic [DATA_W-1:0] rout,
    output logic              rout_en,
    output logic              frm_err
);

    // Half-bit load lands the start-bit check mid-bit; full-bit loads step between centres
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    logic              rxs;
    rx_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [DATA_W-1:0] rout_q,    rout_d;
    logic              rout_en_q, rout_en_d;
    logic              frm_err_q, frm_err_d;
    logic              cnt_zero;

    // Line synchronizer, idle-high reset
    uart_rx_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxs)
    );

    assign cnt_zero = (cnt_q == '0);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            rout_q    <= '0;
            rout_en_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            rout_q    <= rout_d;
            rout_en_q <= rout_en_d;
            frm_err_q <= frm_err_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        rout_d    = rout_q;
        rout_en_d = 1'b0;
        frm_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end

            ST_START: begin
                if (cnt_zero) begin
                    // Line back high at start-bit centre means it was a glitch
                    if (!rxs) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_zero) begin
                    shreg_d = {rxs, shreg_q[DATA_W-1:1]};
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STOP: begin
                // Leaving at stop-bit centre lets a gapless next start bit be caught
                if (cnt_zero) begin
                    if (rxs) begin
                        rout_d    = shreg_q;
                        rout_en_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frm_err_d = 1'b1;
                        state_d   = ST_BRKWT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_BRKWT: begin
                // Hold off until the line returns idle so a break reports once
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rout    = rout_q;
    assign rout_en = rout_en_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: directed frames, glitch, break,
// mid-frame reset, randomized frames against a byte-level model, and a
// CLK_DIV=8 instance driven with a skewed bit period.
`timescale 1ns/1ps
module tb_uart_rx_deser;
    import uart_rx_deser_pkg::*;

    localparam int unsigned DIV  = 16;
    localparam int unsigned DIV8 = 8;
    localparam real         TCLK = 10.0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic       rxd8  = 1'b1;
    logic [7:0] rout;
    logic       rout_en;
    logic       frm_err;
    logic [7:0] rout8;
    logic       rout8_en;
    logic       frm8_err;

    always #5 clk = ~clk;

    uart_rx_deser #(.CLK_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .rout    (rout),
        .rout_en (rout_en),
        .frm_err (frm_err)
    );

    uart_rx_deser #(.CLK_DIV(DIV8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd8),
        .rout    (rout8),
        .rout_en (rout8_en),
        .frm_err (frm8_err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] rx_q[$];
    realtime    en_t_q[$];
    logic [7:0] rx8_q[$];
    int         fe_cnt = 0;
    int         fe8_cnt = 0;
    int         both_cnt = 0;
    int         rst_pulse_cnt = 0;

    // Output monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rout_en) begin
            rx_q.push_back(rout);
            en_t_q.push_back($realtime);
        end
        if (frm_err) fe_cnt++;
        if (rout8_en) rx8_q.push_back(rout8);
        if (frm8_err) fe8_cnt++;
        if ((rout_en && frm_err) || (rout8_en && frm8_err)) both_cnt++;
        if (!rst_n && (rout_en || frm_err || rout8_en || frm8_err)) rst_pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] q8_at(input int i);
        if (i < rx8_q.size()) return rx8_q[i];
        return 8'hxx;
    endfunction

    // Drivers assume they are entered on a falling clock edge
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic send8(input logic [7:0] b, input realtime bt);
        rxd8 = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rxd8 = b[i];
            #(bt);
        end
        rxd8 = 1'b1;
        #(bt);
        #(2.0 * bt);
        @(negedge clk);
    endtask

    initial begin
        int         base;
        int         base8;
        int         fe0;
        int         lat;
        int         exp_fe;
        int         gap;
        realtime    t0;
        logic [7:0] b;
        logic [7:0] last_good;
        logic       good;
        logic [7:0] exp_q[$];
        logic [7:0] a5;
        logic [7:0] sk_b[4];
        realtime    sk_t[4];

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_rout",    32'(rout),    32'h00);
        chk("rst_rout_en", 32'(rout_en), 32'h0);
        chk("rst_frm_err", 32'(frm_err), 32'h0);
        chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("release_quiet", 32'(rx_q.size() + fe_cnt), 32'h0);

        // Single byte 'g' and start-edge to rout_en latency
        base = rx_q.size();
        t0   = $realtime;
        send_frame(8'h67, 1'b1);
        repeat (4) @(negedge clk);
        chk("g_count",   32'(rx_q.size() - base), 32'd1);
        chk("g_data",    32'(q_at(base)), 32'h67);
        chk("g_frm_err", 32'(fe_cnt), 32'd0);
        lat = (en_t_q.size() > base) ? int'((en_t_q[base] - t0) / TCLK) : -1;
        chk("g_latency_155pm1", 32'((lat >= 154) && (lat <= 156)), 32'd1);

        // Back-to-back with no idle bits
        base = rx_q.size();
        send_frame(8'h77, 1'b1);
        send_frame(8'h30, 1'b1);
        send_frame(8'h71, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_count", 32'(rx_q.size() - base), 32'd3);
        chk("b2b_w", 32'(q_at(base)),     32'h77);
        chk("b2b_0", 32'(q_at(base + 1)), 32'h30);
        chk("b2b_q", 32'(q_at(base + 2)), 32'h71);

        // Short low glitch
        base = rx_q.size();
        fe0  = fe_cnt;
        rxd  = 1'b0;
        repeat (5) @(negedge clk);
        rxd  = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("glitch_no_en", 32'(rx_q.size() - base), 32'd0);
        chk("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit followed by a long break
        base = rx_q.size();
        fe0  = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("brk_one_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("brk_no_en",  32'(rx_q.size() - base), 32'd0);
        chk("brk_rout",   32'(rout), 32'h71);
        send_frame(8'h0d, 1'b1);
        repeat (4) @(negedge clk);
        chk("brk_next_count", 32'(rx_q.size() - base), 32'd1);
        chk("brk_next_data",  32'(q_at(base)), 32'h0d);

        // Reset in the middle of data bit 4 of 8'hA5, held into the stop bit
        a5 = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(a5[i]);
        rxd = a5[4];
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_rout",    32'(rout), 32'h00);
        chk("mid_rst_rout_en", 32'(rout_en), 32'h0);
        repeat (DIV / 2 - 2) @(negedge clk);
        for (int i = 5; i < 8; i++) drive_bit(a5[i]);
        rxd = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        chk("mid_rst_rout_late", 32'(rout), 32'h00);
        rst_n = 1'b1;
        repeat (DIV / 2 + DIV) @(negedge clk);
        base = rx_q.size();
        send_frame(8'h31, 1'b1);
        repeat (4) @(negedge clk);
        chk("post_rst_count", 32'(rx_q.size() - base), 32'd1);
        chk("post_rst_data",  32'(q_at(base)), 32'h31);
        chk("no_pulse_in_rst", 32'(rst_pulse_cnt), 32'd0);

        // Randomized frames against a byte-level model
        base      = rx_q.size();
        fe0       = fe_cnt;
        exp_fe    = 0;
        last_good = 8'h31;
        for (int f = 0; f < 24; f++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            if (good) begin
                exp_q.push_back(b);
                last_good = b;
                gap = $urandom_range(0, 2);
            end else begin
                exp_fe++;
                gap = $urandom_range(1, 2);
            end
            rxd = 1'b1;
            repeat (gap * DIV) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("rand_count", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("rand_byte_%0d", i), 32'(q_at(base + i)), 32'(exp_q[i]));
        end
        chk("rand_fe",   32'(fe_cnt - fe0), 32'(exp_fe));
        chk("rand_rout", 32'(rout), 32'(last_good));
        chk("never_both", 32'(both_cnt), 32'd0);

        // CLK_DIV=8 with +/-3% bit period
        base8   = rx8_q.size();
        sk_b[0] = 8'hFF; sk_t[0] = 8.0 * TCLK * 1.03;
        sk_b[1] = 8'h00; sk_t[1] = 8.0 * TCLK * 0.97;
        sk_b[2] = 8'hFF; sk_t[2] = 8.0 * TCLK * 0.97;
        sk_b[3] = 8'h00; sk_t[3] = 8.0 * TCLK * 1.03;
        for (int i = 0; i < 4; i++) send8(sk_b[i], sk_t[i]);
        repeat (4) @(negedge clk);
        chk("skew_count", 32'(rx8_q.size() - base8), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("skew_byte_%0d", i), 32'(q8_at(base8 + i)), 32'(sk_b[i]));
        end
        chk("skew_no_fe", 32'(fe8_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
